// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// seq_pattern_detector
// Serial bit-pattern recogniser with run-time pattern, length-PAT_W history,
// overlap mode, registered match pulse and saturating match counter.
// Optional per-bit don't-care mask: define SEQ_PATTERN_MASK_EN.
// Revision: 1.0
// ============================================================================
module seq_pattern_detector #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101,
  parameter logic             DEFAULT_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
`ifdef SEQ_PATTERN_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int               FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic              ovl_q,  ovl_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              armed_q, armed_d;

  logic [PAT_W-1:0]  w_cmp_mask;
  logic [PAT_W-1:0]  w_hist_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;

`ifdef SEQ_PATTERN_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (cfg_load) begin
      mask_d = cfg_mask;
    end
  end

  assign w_cmp_mask = mask_q;
`else
  assign w_cmp_mask = '1;
`endif

  // Newest bit enters at the LSB so the oldest bit lines up with pattern MSB.
  assign w_hist_shift = {hist_q[PAT_W-2:0], din};
  assign w_fill_inc   = (fill_q == C_FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign w_hit        = (w_fill_inc == C_FILL_FULL) &&
                        (((w_hist_shift ^ pat_q) & w_cmp_mask) == '0);

  always_comb begin
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d  = w_hist_shift;
      fill_d  = w_fill_inc;
      match_d = w_hit;
      if (w_hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end
    end
  end

  // A clear in the same cycle as a match wins; that match is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign armed_d = (fill_d == C_FILL_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= DEFAULT_PAT;
      ovl_q   <= DEFAULT_OVL;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign armed       = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_detector
// Scoreboard bench: a 4-bit/8-bit-count instance and a 2-bit/2-bit-count
// instance share the serial stream; a bit-history model predicts outputs.
// Revision: 1.0
// ============================================================================
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic       clr_count = 1'b0;
  logic [3:0] cfg_pat_a = 4'b1101;
  logic [3:0] cfg_mask_a = 4'b1111;
  logic       cfg_ovl_a = 1'b1;
  logic [1:0] cfg_pat_b = 2'b11;
  logic       cfg_ovl_b = 1'b1;

  logic       match_a, armed_a;
  logic [7:0] count_a;
  logic       match_b, armed_b;
  logic [1:0] count_b;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "init";

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1101), .DEFAULT_OVL(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat_a), .cfg_overlap(cfg_ovl_a),
`ifdef SEQ_PATTERN_MASK_EN
    .cfg_mask(cfg_mask_a),
`endif
    .clr_count(clr_count), .match(match_a), .match_count(count_a),
    .armed(armed_a)
  );

  seq_pattern_detector #(
    .PAT_W(2), .CNT_W(2), .DEFAULT_PAT(2'b11), .DEFAULT_OVL(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pat_b), .cfg_overlap(cfg_ovl_b),
`ifdef SEQ_PATTERN_MASK_EN
    .cfg_mask(2'b11),
`endif
    .clr_count(clr_count), .match(match_b), .match_count(count_b),
    .armed(armed_b)
  );

  typedef struct packed {
    logic       m;
    logic [7:0] c;
    logic       a;
  } exp_t;

  exp_t sb_q[$];

  // Model: every accepted bit since the last clear, newest at bit 0.
  logic [63:0] m_seen[2];
  int          m_n[2];
  logic [31:0] m_pat[2];
  logic [31:0] m_mask[2];
  logic        m_ovl[2];
  int          m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_seen[k] = '0;
      m_n[k]    = 0;
      m_ovl[k]  = 1'b1;
      m_mask[k] = 32'hFFFF_FFFF;
      m_cnt[k]  = 0;
    end
    m_pat[0] = 32'hD;
    m_pat[1] = 32'h3;
  endtask

  task automatic model_step(input int k, input logic d, input logic v,
                            input logic ld, input logic clr,
                            input logic [31:0] pat, input logic [31:0] mask,
                            input logic ovl, output exp_t e);
    int          w;
    int          cmax;
    logic [31:0] fm;
    logic        em;
    w    = (k == 0) ? 4 : 2;
    cmax = (k == 0) ? 255 : 3;
    fm   = (32'h1 << w) - 32'h1;
    em   = 1'b0;
    if (ld) begin
      m_pat[k]  = pat & fm;
      m_mask[k] = mask & fm;
      m_ovl[k]  = ovl;
      m_seen[k] = '0;
      m_n[k]    = 0;
    end else if (v) begin
      m_seen[k] = {m_seen[k][62:0], d};
      m_n[k]++;
      if (m_n[k] >= w && (((m_seen[k][31:0] ^ m_pat[k]) & m_mask[k] & fm) == 32'h0)) begin
        em = 1'b1;
        if (!m_ovl[k]) begin
          m_seen[k] = '0;
          m_n[k]    = 0;
        end
      end
    end
    if (clr) m_cnt[k] = 0;
    else if (em && m_cnt[k] < cmax) m_cnt[k]++;
    e.m = em;
    e.c = 8'(m_cnt[k]);
    e.a = (m_n[k] >= w);
  endtask

  // One clock: drive, predict into the scoreboard, then compare after the edge.
  task automatic step(input logic d, input logic v, input logic ld, input logic clr);
    exp_t        e;
    exp_t        got;
    logic [31:0] eff_mask;
`ifdef SEQ_PATTERN_MASK_EN
    eff_mask = {28'h0, cfg_mask_a};
`else
    eff_mask = 32'hFFFF_FFFF;
`endif
    din = d; din_valid = v; cfg_load = ld; clr_count = clr;
    model_step(0, d, v, ld, clr, {28'h0, cfg_pat_a}, eff_mask, cfg_ovl_a, e);
    sb_q.push_back(e);
    model_step(1, d, v, ld, clr, {30'h0, cfg_pat_b}, 32'hFFFF_FFFF, cfg_ovl_b, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("a_match", 32'(match_a), 32'(got.m));
    chk("a_count", 32'(count_a), 32'(got.c));
    chk("a_armed", 32'(armed_a), 32'(got.a));
    got = sb_q.pop_front();
    chk("b_match", 32'(match_b), 32'(got.m));
    chk("b_count", 32'(count_b), 32'(got.c));
    chk("b_armed", 32'(armed_b), 32'(got.a));
    din_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_a_match", 32'(match_a), 32'h0);
    chk("rst_a_count", 32'(count_a), 32'h0);
    chk("rst_a_armed", 32'(armed_a), 32'h0);
    chk("rst_b_count", 32'(count_b), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    phase = "reset";
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "overlap";
    feed(16'b1101101, 7);
    chk("ovl_total", 32'(count_a), 32'd2);

    phase = "no_overlap";
    cfg_pat_a = 4'b1101; cfg_ovl_a = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b1101101, 7);
    chk("novl_total", 32'(count_a), 32'd3);

    phase = "prefix";
    cfg_ovl_a = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b11101, 5);
    chk("prefix_total", 32'(count_a), 32'd1);

    phase = "gaps";
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "saturate";
    cfg_pat_b = 2'b11; cfg_ovl_b = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    feed(16'b111111, 6);
    chk("b_sat", 32'(count_b), 32'd3);

    phase = "clr_on_match";
    step(1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b110, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1);

    phase = "load_drops_bit";
    feed(16'b110, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    feed(16'b101, 3);

    phase = "async_reset";
    feed(16'b110, 3);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b101, 3);

`ifdef SEQ_PATTERN_MASK_EN
    phase = "mask";
    cfg_pat_a = 4'b1101; cfg_mask_a = 4'b1011; cfg_ovl_a = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b1111, 4);
    cfg_mask_a = 4'b1111;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b1111, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
